// File: rtl/automata_row_writer.sv
// automata_row_writer
// Generates an elementary cellular-automaton frame and streams it, one
// 20-pixel word per cycle, into port A of the shared frame RAM.
// Optional build macro: AUTOMATA_WRAP_EN (toroidal row; edge cells wrap).
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for START
// S_SEED  | writing row 0 from the seed, loading the row buffer
// S_GEN   | writing rows from the rule applied to the row buffer
// S_DONE  | frame complete, irq pulse
// S_WSYNC | continuous mode, waiting for a ready_sig rising edge
module automata_row_writer #(
    parameter int ROW_WORDS = 64,
    parameter int ROWS      = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        write,
    input  logic [2:0]  address,
    input  logic [31:0] writedata,
    input  logic        ready_sig,
    output logic [15:0] address_a,
    output logic [19:0] data_a,
    output logic        wren_a,
    output logic        busy,
    output logic        irq
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SEED  = 3'd1;
    localparam logic [2:0] S_GEN   = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_WSYNC = 3'd4;

    localparam logic [5:0] LAST_WORD = 6'(ROW_WORDS - 1);
    localparam logic [5:0] SEED_WORD = 6'(ROW_WORDS / 2);
    localparam logic [9:0] LAST_ROW  = 10'(ROWS - 1);

    logic [2:0]  state;
    logic        cont;
    logic        smode_reg;
    logic [7:0]  rule_reg;
    logic [19:0] seed_reg;
    logic        smode_sh;
    logic [7:0]  rule_sh;
    logic [19:0] seed_sh;
    logic [9:0]  row;
    logic [5:0]  word;
    logic [19:0] row_buf [ROW_WORDS];
    logic        lagw;          // old LSB of word w-1, i.e. left neighbour of word w
    logic        ready_q;
`ifdef AUTOMATA_WRAP_EN
    logic        first_msb;     // old leftmost pixel of the row, right neighbour of the last pixel
`endif

    logic        reg_wr;
    logic        ctrl_wr;
    logic        start_req;
    logic        cont_next;
    logic        ready_rise;
    logic [5:0]  word_inc;
    logic [19:0] old_word;
    logic        left_n;
    logic        right_n;
    logic [21:0] ext;
    logic [19:0] gen_word;
    logic [19:0] seed_word;
    logic        unused_ok;

    assign unused_ok = &{1'b0, writedata[31:20]};

    // Register decode and edge detect.
    always_comb begin
        reg_wr     = chipselect && write;
        ctrl_wr    = reg_wr && (address == 3'd0);
        start_req  = ctrl_wr && writedata[0] && (state == S_IDLE);
        cont_next  = ctrl_wr ? writedata[1] : cont;
        ready_rise = ready_sig && !ready_q;
    end

    // Next-word computation for seed and rule rows.
    always_comb begin
        word_inc = word + 6'd1;
        old_word = row_buf[word];
`ifdef AUTOMATA_WRAP_EN
        left_n  = (word == 6'd0) ? row_buf[LAST_WORD][0] : lagw;
        right_n = (word == LAST_WORD) ? first_msb : row_buf[word_inc][19];
`else
        left_n  = (word == 6'd0) ? 1'b0 : lagw;
        right_n = (word == LAST_WORD) ? 1'b0 : row_buf[word_inc][19];
`endif
        ext = {left_n, old_word, right_n};
        gen_word = '0;
        for (int b = 0; b < 20; b++) begin
            gen_word[b] = rule_sh[ext[b +: 3]];
        end
        if (smode_sh) begin
            seed_word = seed_sh;
        end else begin
            seed_word = (word == SEED_WORD) ? 20'h80000 : 20'h00000;
        end
    end

    // RAM port and status outputs follow the state directly, so reset clears them at once.
    always_comb begin
        wren_a    = (state == S_SEED) || (state == S_GEN);
        busy      = wren_a;
        irq       = (state == S_DONE);
        address_a = {row, word};
        if (state == S_SEED) begin
            data_a = seed_word;
        end else if (state == S_GEN) begin
            data_a = gen_word;
        end else begin
            data_a = 20'h00000;
        end
    end

    // Software-visible registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cont      <= 1'b0;
            smode_reg <= 1'b0;
            rule_reg  <= 8'h00;
            seed_reg  <= 20'h00000;
        end else if (reg_wr) begin
            case (address)
                3'd0: begin
                    cont      <= writedata[1];
                    smode_reg <= writedata[2];
                end
                3'd1: rule_reg <= writedata[7:0];
                3'd2: seed_reg <= writedata[19:0];
                default: ;
            endcase
        end
    end

    // One-flop history of the frame-sync strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= ready_sig;
        end
    end

    // Frame sequencer, position counters and row buffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            smode_sh <= 1'b0;
            rule_sh  <= 8'h00;
            seed_sh  <= 20'h00000;
            row      <= 10'd0;
            word     <= 6'd0;
            lagw     <= 1'b0;
`ifdef AUTOMATA_WRAP_EN
            first_msb <= 1'b0;
`endif
            for (int i = 0; i < ROW_WORDS; i++) begin
                row_buf[i] <= 20'h00000;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_req) begin
                        state    <= S_SEED;
                        row      <= 10'd0;
                        word     <= 6'd0;
                        rule_sh  <= rule_reg;
                        seed_sh  <= seed_reg;
                        smode_sh <= writedata[2];
                    end
                end
                S_SEED: begin
                    row_buf[word] <= seed_word;
                    if (word == LAST_WORD) begin
                        word  <= 6'd0;
                        row   <= 10'd1;
                        state <= S_GEN;
                    end else begin
                        word <= word_inc;
                    end
                end
                S_GEN: begin
                    row_buf[word] <= gen_word;
                    lagw          <= old_word[0];
`ifdef AUTOMATA_WRAP_EN
                    if (word == 6'd0) begin
                        first_msb <= old_word[19];
                    end
`endif
                    if (word == LAST_WORD) begin
                        word <= 6'd0;
                        if (row == LAST_ROW) begin
                            row   <= 10'd0;
                            state <= S_DONE;
                        end else begin
                            row <= row + 10'd1;
                        end
                    end else begin
                        word <= word_inc;
                    end
                end
                S_DONE: begin
                    state <= cont_next ? S_WSYNC : S_IDLE;
                end
                S_WSYNC: begin
                    if (!cont_next) begin
                        state <= S_IDLE;
                    end else if (ready_rise) begin
                        // Row 0 is derived from the buffer so the pattern carries on.
                        state    <= S_GEN;
                        row      <= 10'd0;
                        word     <= 6'd0;
                        rule_sh  <= rule_reg;
                        seed_sh  <= seed_reg;
                        smode_sh <= smode_reg;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_automata_row_writer.sv
// Directed bench for automata_row_writer, built with a short frame (16 rows).
module tb_automata_row_writer;

    localparam int NROWS  = 16;
    localparam int NWORDS = 64;
    localparam int FRAME  = NROWS * NWORDS;
    localparam int BUDGET = FRAME + 200;
`ifdef AUTOMATA_WRAP_EN
    localparam logic [19:0] EXP_W63 = 20'h00001;
`else
    localparam logic [19:0] EXP_W63 = 20'h00000;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        chipselect;
    logic        write;
    logic [2:0]  address;
    logic [31:0] writedata;
    logic        ready_sig;
    logic [15:0] address_a;
    logic [19:0] data_a;
    logic        wren_a;
    logic        busy;
    logic        irq;

    int total = 0;
    int bad   = 0;

    logic [19:0] mem [0:FRAME-1];
    int fr_writes, fr_busy, fr_irq, seq_err, wb_err;
    bit fr_done;
    int q_wr, q_irq;

    automata_row_writer #(.ROW_WORDS(NWORDS), .ROWS(NROWS)) dut (
        .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
        .address(address), .writedata(writedata), .ready_sig(ready_sig),
        .address_a(address_a), .data_a(data_a), .wren_a(wren_a),
        .busy(busy), .irq(irq)
    );

    always #5 clk = ~clk;

    // Called at a negedge; one-cycle Avalon write, returns at the next negedge.
    task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < FRAME; i++) mem[i] = 'x;
    endtask

    // Collects one frame starting at the current negedge, stopping at irq.
    task automatic run_frame(input int inject_at);
        bit injected = 0;
        fr_writes = 0; fr_busy = 0; fr_irq = 0; seq_err = 0; wb_err = 0; fr_done = 0;
        for (int c = 0; c < BUDGET && !fr_done; c++) begin
            if (wren_a !== busy) wb_err++;
            if (wren_a === 1'b1) begin
                if (address_a !== 16'(fr_writes)) seq_err++;
                if (fr_writes < FRAME) mem[address_a[9:0]] = data_a;
                fr_writes++;
            end
            if (busy === 1'b1) fr_busy++;
            if (irq === 1'b1) begin
                fr_irq++;
                fr_done = 1;
                if (busy !== 1'b0) wb_err++;
            end
            if (!injected && inject_at >= 0 && fr_writes == inject_at) begin
                chipselect = 1'b1; write = 1'b1; address = 3'd0; writedata = 32'h1;
                injected = 1;
            end else begin
                chipselect = 1'b0; write = 1'b0;
            end
            if (!fr_done) @(negedge clk);
        end
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        q_wr = 0; q_irq = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (wren_a !== 1'b0) q_wr++;
            if (irq !== 1'b0) q_irq++;
        end
    endtask

    task automatic check_frame_counts(input string name);
        total++;
        if (!fr_done) begin bad++; $display("FAIL %s_timeout got=no_irq exp=irq", name); end
        total++;
        if (fr_writes != FRAME) begin bad++; $display("FAIL %s_writes got=%0d exp=%0d", name, fr_writes, FRAME); end
        total++;
        if (fr_busy != FRAME) begin bad++; $display("FAIL %s_busy got=%0d exp=%0d", name, fr_busy, FRAME); end
        total++;
        if (seq_err != 0) begin bad++; $display("FAIL %s_addr_seq got=%0d exp=0", name, seq_err); end
        total++;
        if (wb_err != 0) begin bad++; $display("FAIL %s_busy_wren got=%0d exp=0", name, wb_err); end
        total++;
        if (fr_irq != 1) begin bad++; $display("FAIL %s_irq got=%0d exp=1", name, fr_irq); end
    endtask

    task automatic test_reset();
        reset = 1'b0; chipselect = 1'b0; write = 1'b0; address = 3'd0;
        writedata = 32'h0; ready_sig = 1'b0;
        @(negedge clk); @(negedge clk);
        total++;
        if ({wren_a, busy, irq, address_a, data_a} !== 39'h0) begin
            bad++;
            $display("FAIL reset_outputs got=%b/%b/%b/%h/%h exp=0", wren_a, busy, irq, address_a, data_a);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_rule90();
        int e0 = 0, e1 = 0;
        reg_write(3'd1, 32'h5A);
        total++;
        if (wren_a !== 1'b0) begin bad++; $display("FAIL r90_pre_start got=%b exp=0", wren_a); end
        clear_mem();
        reg_write(3'd0, 32'h1);
        total++;
        if (wren_a !== 1'b1 || address_a !== 16'h0) begin
            bad++; $display("FAIL r90_first_write got=%b/%h exp=1/0000", wren_a, address_a);
        end
        run_frame(-1);
        check_frame_counts("r90");
        for (int w = 0; w < NWORDS; w++) begin
            if (mem[w] !== ((w == 32) ? 20'h80000 : 20'h0)) e0++;
            if (mem[NWORDS + w] !== ((w == 31) ? 20'h00001 : (w == 32) ? 20'h40000 : 20'h0)) e1++;
        end
        total++;
        if (e0 != 0) begin bad++; $display("FAIL r90_row0 got=%0d_bad_words exp=0 w32=%h", e0, mem[32]); end
        total++;
        if (e1 != 0) begin bad++; $display("FAIL r90_row1 got=%0d_bad_words exp=0 w31=%h w32=%h", e1, mem[95], mem[96]); end
        idle_cycles(10);
        total++;
        if (q_wr != 0 || q_irq != 0) begin bad++; $display("FAIL r90_after got=%0d/%0d exp=0/0", q_wr, q_irq); end
    endtask

    task automatic test_rule0_seed();
        int e0 = 0, er = 0;
        reg_write(3'd1, 32'h00);
        reg_write(3'd2, 32'hFFFFF);
        clear_mem();
        reg_write(3'd0, 32'h5);
        run_frame(-1);
        check_frame_counts("r0");
        for (int i = 0; i < FRAME; i++) begin
            if (i < NWORDS) begin
                if (mem[i] !== 20'hFFFFF) e0++;
            end else if (mem[i] !== 20'h0) er++;
        end
        total++;
        if (e0 != 0) begin bad++; $display("FAIL r0_row0 got=%0d_bad_words exp=0", e0); end
        total++;
        if (er != 0) begin bad++; $display("FAIL r0_rows got=%0d_bad_words exp=0", er); end
    endtask

    task automatic test_rule170();
        int e1 = 0;
        reg_write(3'd1, 32'hAA);
        reg_write(3'd2, 32'h80000);
        clear_mem();
        reg_write(3'd0, 32'h5);
        run_frame(-1);
        check_frame_counts("r170");
        for (int w = 0; w < NWORDS - 1; w++) if (mem[NWORDS + w] !== 20'h00001) e1++;
        total++;
        if (e1 != 0) begin bad++; $display("FAIL r170_row1 got=%0d_bad_words exp=0", e1); end
        total++;
        if (mem[2 * NWORDS - 1] !== EXP_W63) begin
            bad++; $display("FAIL r170_w63 got=%h exp=%h", mem[2 * NWORDS - 1], EXP_W63);
        end
    endtask

    task automatic test_cont();
        int e = 0;
        reg_write(3'd1, 32'hCC);
        reg_write(3'd2, 32'h12345);
        ready_sig = 1'b1;
        clear_mem();
        reg_write(3'd0, 32'h7);
        run_frame(-1);
        check_frame_counts("cont1");
        for (int i = 0; i < FRAME; i++) if (mem[i] !== 20'h12345) e++;
        total++;
        if (e != 0) begin bad++; $display("FAIL cont1_data got=%0d_bad_words exp=0", e); end
        idle_cycles(20);
        total++;
        if (q_wr != 0) begin bad++; $display("FAIL cont_level_no_edge got=%0d exp=0", q_wr); end
        @(negedge clk);
        reg_write(3'd2, 32'h0);
        ready_sig = 1'b0;
        idle_cycles(3);
        total++;
        if (q_wr != 0 || busy !== 1'b0) begin bad++; $display("FAIL cont_wait got=%0d/%b exp=0/0", q_wr, busy); end
        ready_sig = 1'b1;
        @(negedge clk);
        total++;
        if (wren_a !== 1'b1 || address_a !== 16'h0) begin
            bad++; $display("FAIL cont_edge_start got=%b/%h exp=1/0000", wren_a, address_a);
        end
        clear_mem();
        run_frame(-1);
        check_frame_counts("cont2");
        e = 0;
        for (int i = 0; i < FRAME; i++) if (mem[i] !== 20'h12345) e++;
        total++;
        if (e != 0) begin bad++; $display("FAIL cont2_data got=%0d_bad_words exp=0", e); end
        @(negedge clk);
        reg_write(3'd0, 32'h0);
        ready_sig = 1'b0;
        @(negedge clk);
        ready_sig = 1'b1;
        idle_cycles(6);
        total++;
        if (q_wr != 0 || q_irq != 0) begin bad++; $display("FAIL cont_cleared got=%0d/%0d exp=0/0", q_wr, q_irq); end
    endtask

    task automatic test_reset_mid();
        int cnt = 0;
        bit hit = 0;
        ready_sig = 1'b0;
        reg_write(3'd1, 32'h5A);
        reg_write(3'd0, 32'h1);
        for (int c = 0; c < BUDGET && !hit; c++) begin
            if (wren_a === 1'b1) cnt++;
            if (cnt == 300) hit = 1; else @(negedge clk);
        end
        total++;
        if (!hit) begin bad++; $display("FAIL rst_mid_reach got=%0d exp=300", cnt); end
        reset = 1'b0;
        #1;
        total++;
        if (wren_a !== 1'b0) begin bad++; $display("FAIL rst_mid_wren got=%b exp=0", wren_a); end
        total++;
        if ({busy, irq, address_a, data_a} !== 38'h0) begin
            bad++; $display("FAIL rst_mid_outputs got=%b/%b/%h/%h exp=0", busy, irq, address_a, data_a);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reg_write(3'd1, 32'h5A);
        clear_mem();
        reg_write(3'd0, 32'h1);
        total++;
        if (wren_a !== 1'b1 || address_a !== 16'h0) begin
            bad++; $display("FAIL rst_restart got=%b/%h exp=1/0000", wren_a, address_a);
        end
        run_frame(-1);
        check_frame_counts("rst_frame");
        total++;
        if (mem[NWORDS + 31] !== 20'h00001) begin bad++; $display("FAIL rst_row1 got=%h exp=00001", mem[NWORDS + 31]); end
    endtask

    task automatic test_busy_start();
        @(negedge clk);
        reg_write(3'd1, 32'h00);
        reg_write(3'd0, 32'h1);
        run_frame(100);
        check_frame_counts("busy_start");
        idle_cycles(10);
        total++;
        if (q_wr != 0 || q_irq != 0) begin bad++; $display("FAIL busy_start_after got=%0d/%0d exp=0/0", q_wr, q_irq); end
    endtask

    initial begin
        test_reset();
        test_rule90();
        test_rule0_seed();
        test_rule170();
        test_cont();
        test_reset_mid();
        test_busy_start();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
